// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Write-back pipeline stage. Registers the retiring instruction,
//            selects the write data (result or link address), suppresses
//            integer writes to r0 and, when WB_FWD_HIST_EN is defined, keeps
//            a short history of retired writes that two independent
//            forwarding query ports can search combinationally.
// Ports    : clk, rst_n (sync, active-low), stall, flush
//            in_valid/in_regwr/in_rw/in_busw/in_fpoint/in_link/in_jal : upstream
//            regwr/rw/busW/fpoint                                     : RF write
//            qa_rw/qa_fp, qb_rw/qb_fp                                 : queries
//            fwd_hit_a/b, fwd_data_a/b                                : answers
// Macro    : WB_FWD_HIST_EN enables the history buffer and query ports.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int FP_W       = 2,
    parameter int HIST_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_regwr,
    input  logic [REG_AW-1:0] in_rw,
    input  logic [DATA_W-1:0] in_busw,
    input  logic [FP_W-1:0]   in_fpoint,
    input  logic [DATA_W-1:0] in_link,
    input  logic              in_jal,
    output logic              regwr,
    output logic [REG_AW-1:0] rw,
    output logic [DATA_W-1:0] busW,
    output logic [FP_W-1:0]   fpoint,
    input  logic [REG_AW-1:0] qa_rw,
    input  logic [FP_W-1:0]   qa_fp,
    input  logic [REG_AW-1:0] qb_rw,
    input  logic [FP_W-1:0]   qb_fp,
    output logic              fwd_hit_a,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_b
);

    logic              r_valid;
    logic              r_regwr;
    logic [REG_AW-1:0] r_rw;
    logic [DATA_W-1:0] r_busw;
    logic [FP_W-1:0]   r_fpoint;
    logic [DATA_W-1:0] r_link;
    logic              r_jal;

    // Stage register: reset beats flush beats stall beats load.
    // A flush only kills valid/regwr; the payload fields are don't-care.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_regwr  <= 1'b0;
            r_rw     <= '0;
            r_busw   <= '0;
            r_fpoint <= '0;
            r_link   <= '0;
            r_jal    <= 1'b0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_regwr  <= 1'b0;
        end else if (!stall) begin
            r_valid  <= in_valid;
            r_regwr  <= in_regwr;
            r_rw     <= in_rw;
            r_busw   <= in_busw;
            r_fpoint <= in_fpoint;
            r_link   <= in_link;
            r_jal    <= in_jal;
        end
    end

    // Integer r0 is hard-wired to zero, so a write to it is never issued.
    logic w_int_r0;
    assign w_int_r0 = (r_fpoint == '0) && (r_rw == '0);

    assign regwr  = r_valid & r_regwr & ~w_int_r0;
    assign rw     = r_rw;
    assign fpoint = r_fpoint;
    assign busW   = r_jal ? r_link : r_busw;

`ifdef WB_FWD_HIST_EN
    logic [HIST_DEPTH-1:0] r_hv;
    logic [REG_AW-1:0]     r_hrw   [HIST_DEPTH];
    logic [FP_W-1:0]       r_hfp   [HIST_DEPTH];
    logic [DATA_W-1:0]     r_hdata [HIST_DEPTH];

    // Shift register of retired writes; entry 0 is the youngest. A flushed
    // bubble enters with v=0 because regwr is already 0 for it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hv <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                r_hrw[k]   <= '0;
                r_hfp[k]   <= '0;
                r_hdata[k] <= '0;
            end
        end else if (!stall) begin
            r_hv[0]    <= regwr;
            r_hrw[0]   <= rw;
            r_hfp[0]   <= fpoint;
            r_hdata[0] <= busW;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                r_hv[k]    <= r_hv[k-1];
                r_hrw[k]   <= r_hrw[k-1];
                r_hfp[k]   <= r_hfp[k-1];
                r_hdata[k] <= r_hdata[k-1];
            end
        end
    end

    // Returns {hit, data}. Sources are scanned oldest first so that a younger
    // match overwrites an older one; the live stage output is checked last
    // and therefore has the highest priority.
    function automatic logic [DATA_W:0] lookup(input logic [REG_AW-1:0] q_rw,
                                               input logic [FP_W-1:0]   q_fp);
        logic [DATA_W:0] res;
        res = '0;
        if (!((q_fp == '0) && (q_rw == '0))) begin
            for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
                if (r_hv[k] && (r_hrw[k] == q_rw) && (r_hfp[k] == q_fp))
                    res = {1'b1, r_hdata[k]};
            end
            if (regwr && (rw == q_rw) && (fpoint == q_fp))
                res = {1'b1, busW};
        end
        return res;
    endfunction

    assign {fwd_hit_a, fwd_data_a} = lookup(qa_rw, qa_fp);
    assign {fwd_hit_b, fwd_data_b} = lookup(qb_rw, qb_fp);
`else
    // No history: forwarding answers are constant and the queries are unused.
    logic w_unused_query;
    assign w_unused_query = ^{qa_rw, qa_fp, qb_rw, qb_fp};

    assign fwd_hit_a  = 1'b0;
    assign fwd_data_a = '0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_b = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed self-checking bench for wb_stage. History/forwarding
//            checks adapt to whether WB_FWD_HIST_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_regwr;
    logic [4:0]  in_rw;
    logic [31:0] in_busw;
    logic [1:0]  in_fpoint;
    logic [31:0] in_link;
    logic        in_jal;
    logic        regwr;
    logic [4:0]  rw;
    logic [31:0] busW;
    logic [1:0]  fpoint;
    logic [4:0]  qa_rw;
    logic [1:0]  qa_fp;
    logic [4:0]  qb_rw;
    logic [1:0]  qb_fp;
    logic        fwd_hit_a;
    logic [31:0] fwd_data_a;
    logic        fwd_hit_b;
    logic [31:0] fwd_data_b;

    int vectors    = 0;
    int miscompares = 0;

    wb_stage #(
        .DATA_W(32), .REG_AW(5), .FP_W(2), .HIST_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwr(in_regwr), .in_rw(in_rw),
        .in_busw(in_busw), .in_fpoint(in_fpoint), .in_link(in_link),
        .in_jal(in_jal),
        .regwr(regwr), .rw(rw), .busW(busW), .fpoint(fpoint),
        .qa_rw(qa_rw), .qa_fp(qa_fp), .qb_rw(qb_rw), .qb_fp(qb_fp),
        .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
        .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] r, input logic [1:0] fp,
                         input logic [31:0] d);
        in_valid  = 1'b1;
        in_regwr  = 1'b1;
        in_rw     = r;
        in_fpoint = fp;
        in_busw   = d;
        in_jal    = 1'b0;
        in_link   = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(5'd7, 2'd0, 32'hFFFF_FFFF);
        qa_rw = 5'd7; qa_fp = 2'd0; qb_rw = 5'd7; qb_fp = 2'd0;
        step(); step();
        vectors++;
        if (regwr !== 1'b0) begin miscompares++; $display("FAIL reset_regwr got=%b exp=0", regwr); end
        vectors++;
        if (rw !== 5'd0) begin miscompares++; $display("FAIL reset_rw got=%0d exp=0", rw); end
        vectors++;
        if (busW !== 32'h0) begin miscompares++; $display("FAIL reset_busW got=%h exp=0", busW); end
        vectors++;
        if (fpoint !== 2'd0) begin miscompares++; $display("FAIL reset_fpoint got=%0d exp=0", fpoint); end
        vectors++;
        if ({fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b} !== 66'h0) begin
            miscompares++;
            $display("FAIL reset_fwd got=%b/%h %b/%h exp=0", fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b);
        end
    endtask

    task automatic test_load();
        rst_n = 1'b1;
        drive(5'd8, 2'd0, 32'h1234);
        in_link = 32'h999;
        step();
        vectors++;
        if ({regwr, rw, busW} !== {1'b1, 5'd8, 32'h0000_1234}) begin
            miscompares++;
            $display("FAIL load got regwr=%b rw=%0d busW=%h exp 1/8/00001234", regwr, rw, busW);
        end
    endtask

    task automatic test_jal_r0();
        drive(5'd3, 2'd0, 32'hDEAD);
        in_jal = 1'b1; in_link = 32'h0040_0010;
        step();
        vectors++;
        if ({regwr, busW} !== {1'b1, 32'h0040_0010}) begin
            miscompares++;
            $display("FAIL jal got regwr=%b busW=%h exp 1/00400010", regwr, busW);
        end
        drive(5'd0, 2'd0, 32'h77);
        step();
        vectors++;
        if (regwr !== 1'b0) begin miscompares++; $display("FAIL int_r0 got regwr=%b exp=0", regwr); end
        drive(5'd0, 2'd1, 32'h77);
        step();
        vectors++;
        if ({regwr, fpoint, busW} !== {1'b1, 2'd1, 32'h77}) begin
            miscompares++;
            $display("FAIL fp_r0 got regwr=%b fp=%0d busW=%h exp 1/1/77", regwr, fpoint, busW);
        end
        drive(5'd4, 2'd0, 32'h44);
        in_valid = 1'b0;
        step();
        vectors++;
        if (regwr !== 1'b0) begin miscompares++; $display("FAIL invalid got regwr=%b exp=0", regwr); end
    endtask

    task automatic test_stall();
        drive(5'd9, 2'd0, 32'h55);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(5'(10 + i), 2'd2, 32'(i));
            step();
            vectors++;
            if ({regwr, rw, fpoint, busW} !== {1'b1, 5'd9, 2'd0, 32'h55}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got %b/%0d/%0d/%h exp 1/9/0/55", i, regwr, rw, fpoint, busW);
            end
        end
        stall = 1'b0;
        step();
        vectors++;
        if ({rw, fpoint, busW} !== {5'd12, 2'd2, 32'h2}) begin
            miscompares++;
            $display("FAIL stall_release got rw=%0d fp=%0d busW=%h exp 12/2/2", rw, fpoint, busW);
        end
        stall = 1'b1; flush = 1'b1;
        drive(5'd13, 2'd0, 32'h13);
        step();
        stall = 1'b0; flush = 1'b0;
        vectors++;
        if (regwr !== 1'b0) begin miscompares++; $display("FAIL stall_flush got regwr=%b exp=0", regwr); end
    endtask

    task automatic test_history();
        qa_rw = 5'd5; qa_fp = 2'd0; qb_rw = 5'd5; qb_fp = 2'd1;
        drive(5'd5, 2'd0, 32'hA); step();
        drive(5'd5, 2'd0, 32'hB); step();
`ifdef WB_FWD_HIST_EN
        vectors++;
        if ({fwd_hit_a, fwd_data_a} !== {1'b1, 32'hB}) begin
            miscompares++; $display("FAIL hist_stage got %b/%h exp 1/B", fwd_hit_a, fwd_data_a);
        end
        drive(5'd6, 2'd0, 32'h6); step();
        // stage=r6, entry0=r5/B, entry1=r5/A: the younger entry must win
        vectors++;
        if ({fwd_hit_a, fwd_data_a} !== {1'b1, 32'hB}) begin
            miscompares++; $display("FAIL hist_young got %b/%h exp 1/B", fwd_hit_a, fwd_data_a);
        end
        drive(5'd7, 2'd0, 32'h7); step();
        vectors++;
        if ({fwd_hit_a, fwd_data_a} !== {1'b1, 32'hB}) begin
            miscompares++; $display("FAIL hist_e1 got %b/%h exp 1/B", fwd_hit_a, fwd_data_a);
        end
        drive(5'd8, 2'd0, 32'h8); step();
        vectors++;
        if ({fwd_hit_a, fwd_data_a} !== {1'b0, 32'h0}) begin
            miscompares++; $display("FAIL hist_aged got %b/%h exp 0/0", fwd_hit_a, fwd_data_a);
        end
        vectors++;
        if ({fwd_hit_b, fwd_data_b} !== {1'b0, 32'h0}) begin
            miscompares++; $display("FAIL hist_fpclass got %b/%h exp 0/0", fwd_hit_b, fwd_data_b);
        end
        // Flush: stage becomes a bubble, r8 moves into entry0.
        qa_rw = 5'd8; qa_fp = 2'd0; qb_rw = 5'd8; qb_fp = 2'd0;
        drive(5'd8, 2'd0, 32'h99);
        flush = 1'b1; step(); flush = 1'b0;
        vectors++;
        if ({fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b} !== {1'b1, 32'h8, 1'b1, 32'h8}) begin
            miscompares++;
            $display("FAIL hist_flush got %b/%h %b/%h exp 1/8 1/8", fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b);
        end
        stall = 1'b1; step(); step(); stall = 1'b0;
        vectors++;
        if ({fwd_hit_a, fwd_data_a} !== {1'b1, 32'h8}) begin
            miscompares++; $display("FAIL hist_stall got %b/%h exp 1/8", fwd_hit_a, fwd_data_a);
        end
        // Bubble retires into entry0 and r8 into entry1; r8 still visible.
        drive(5'd9, 2'd0, 32'h9); step();
        vectors++;
        if ({fwd_hit_a, fwd_data_a} !== {1'b1, 32'h8}) begin
            miscompares++; $display("FAIL hist_bubble got %b/%h exp 1/8", fwd_hit_a, fwd_data_a);
        end
`else
        vectors++;
        if ({fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b} !== 66'h0) begin
            miscompares++;
            $display("FAIL nohist_fwd got %b/%h %b/%h exp 0", fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b);
        end
`endif
    endtask

    task automatic test_reset_mid();
        drive(5'd5, 2'd0, 32'hC); step();
        drive(5'd6, 2'd1, 32'hD);
        qa_rw = 5'd5; qa_fp = 2'd0; qb_rw = 5'd6; qb_fp = 2'd1;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        in_valid = 1'b0;
        vectors++;
        if ({regwr, rw, busW, fpoint} !== 40'h0) begin
            miscompares++;
            $display("FAIL midreset_out got %b/%0d/%h/%0d exp 0", regwr, rw, busW, fpoint);
        end
        vectors++;
        if ({fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b} !== 66'h0) begin
            miscompares++;
            $display("FAIL midreset_fwd got %b/%h %b/%h exp 0", fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b);
        end
        step();
        vectors++;
        if (fwd_hit_a !== 1'b0) begin miscompares++; $display("FAIL midreset_hist got=%b exp=0", fwd_hit_a); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_jal_r0();
        test_stall();
        test_history();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
